soc_system_sysid_ext: RTL and testbench

//  Next-generation system ID slave on the HPS lightweight bridge. Avalon-MM register file holding the

---
 rtl/soc_system_sysid_pkg.sv | 28 ++
 rtl/soc_system_sysid_uptime.sv | 41 ++++
 rtl/soc_system_sysid_ext.sv | 88 ++++++++
 tb/tb_soc_system_sysid_ext.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/soc_system_sysid_pkg.sv
// System ID slave: register offsets, map version and CAPS word layout.
package soc_system_sysid_pkg;

  localparam logic [2:0] OFF_ID        = 3'd0;
  localparam logic [2:0] OFF_TIMESTAMP = 3'd1;
  localparam logic [2:0] OFF_USER_INFO = 3'd2;
  localparam logic [2:0] OFF_SCRATCH   = 3'd3;
  localparam logic [2:0] OFF_UPTIME_LO = 3'd4;
  localparam logic [2:0] OFF_UPTIME_HI = 3'd5;
  localparam logic [2:0] OFF_CAPS      = 3'd6;

  localparam logic [7:0] MAP_VERSION = 8'h02;

  localparam int CAPS_UPTIME_BIT = 0;
  localparam int CAPS_TICK_LSB   = 8;
  localparam int CAPS_VER_LSB    = 24;

  // Assemble the CAPS word from its fields.
  function automatic logic [31:0] caps_word(input logic uptime, input logic [15:0] tick);
    logic [31:0] w;
    w = '0;
    w[CAPS_UPTIME_BIT]               = uptime;
    w[CAPS_TICK_LSB +: 16]           = tick;
    w[CAPS_VER_LSB +: 8]             = MAP_VERSION;
    return w;
  endfunction

endpackage

// File: rtl/soc_system_sysid_uptime.sv
// Free-running 64-bit uptime counter with prescaler and coherent high-word shadow.
// lo and the shadow capture both reflect the value after the current edge, so a
// LO read taken on a carry edge pairs with the carried high word.
module soc_system_sysid_uptime #(
  parameter int TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        snap_lo,
  output logic [31:0] lo,
  output logic [31:0] hi_shadow
);

  localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

  logic [15:0] pre;
  logic [63:0] cnt;
  logic [63:0] cnt_nxt;
  logic        wrap;

  // Tick on prescaler wrap; the 64-bit add rolls over naturally.
  always_comb begin
    wrap    = (pre == PRE_LAST);
    cnt_nxt = cnt + {63'd0, wrap};
    lo      = cnt_nxt[31:0];
  end

  // Prescaler, counter and snapshot of the high word on a LO read.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre       <= '0;
      cnt       <= '0;
      hi_shadow <= '0;
    end else begin
      pre <= wrap ? 16'd0 : pre + 16'd1;
      cnt <= cnt_nxt;
      if (snap_lo) hi_shadow <= cnt_nxt[63:32];
    end
  end

endmodule

// File: rtl/soc_system_sysid_ext.sv
// System ID Avalon-MM slave: ID/timestamp/user words, byte-lane scratch,
// capability word and optional uptime counter (built when SOC_SYSID_UPTIME_EN
// is defined). Fixed read latency of one clock, no wait states.
module soc_system_sysid_ext
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = 32'hACD51302,
  parameter logic [31:0] TIMESTAMP   = 32'h53796574,
  parameter logic [31:0] USER_INFO   = 32'h0000_0000,
  parameter int          TICK_DIV    = 1,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [31:0] scratch;
  logic [31:0] up_lo;
  logic [31:0] up_hi;
  logic [31:0] rd_mux;

`ifdef SOC_SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
  logic snap_lo;

  assign snap_lo = read && (address == OFF_UPTIME_LO);

  soc_system_sysid_uptime #(
    .TICK_DIV (TICK_DIV)
  ) u_uptime (
    .clock     (clock),
    .reset     (reset),
    .snap_lo   (snap_lo),
    .lo        (up_lo),
    .hi_shadow (up_hi)
  );
`else
  localparam logic UPTIME_PRESENT = 1'b0;
  assign up_lo = '0;
  assign up_hi = '0;
`endif

  localparam logic [31:0] CAPS = caps_word(UPTIME_PRESENT, 16'(TICK_DIV));

  // Address decode; reserved offset reads zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      OFF_ID:        rd_mux = ID_VALUE;
      OFF_TIMESTAMP: rd_mux = TIMESTAMP;
      OFF_USER_INFO: rd_mux = USER_INFO;
      OFF_SCRATCH:   rd_mux = scratch;
      OFF_UPTIME_LO: rd_mux = up_lo;
      OFF_UPTIME_HI: rd_mux = up_hi;
      OFF_CAPS:      rd_mux = CAPS;
      default:       rd_mux = '0;
    endcase
  end

  // Scratch register, byte-lane writes; other offsets ignore writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      scratch <= SCRATCH_RST;
    end else if (write && (address == OFF_SCRATCH)) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) scratch[b*8 +: 8] <= writedata[b*8 +: 8];
    end
  end

  // Read response register; data holds between reads, a same-cycle write is seen next read.
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// Directed bench for soc_system_sysid_ext (TICK_DIV=4). Uptime checks are
// compiled in when SOC_SYSID_UPTIME_EN is defined, zero-read checks otherwise.
module tb_soc_system_sysid_ext;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int errors = 0;
  int checks = 0;

`ifdef SOC_SYSID_UPTIME_EN
  localparam logic [31:0] EXP_CAPS = 32'h0200_0401;
`else
  localparam logic [31:0] EXP_CAPS = 32'h0200_0400;
`endif

  soc_system_sysid_ext #(
    .TICK_DIV (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; read = 1'b0; write = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  // One-cycle read; response is sampled just after the capturing edge.
  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    idle(1);
    read = 1'b0;
    chk("rdvalid", {31'd0, readdatavalid}, 32'd1);
    d = readdata;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    address = a; writedata = wd; byteenable = be; write = 1'b1;
    idle(1);
    write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;

    // Reset state
    do_reset();
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_rdv", {31'd0, readdatavalid}, 32'd0);

    // T1: ID and timestamp, valid drops and data holds afterwards
    do_read(3'd0, d); chk("id", d, 32'hACD51302);
    do_read(3'd1, d); chk("timestamp", d, 32'h53796574);
    idle(1);
    chk("rdv_low", {31'd0, readdatavalid}, 32'd0);
    chk("rdata_hold", readdata, 32'h53796574);
    do_read(3'd2, d); chk("user_info", d, 32'd0);
    do_read(3'd6, d); chk("caps", d, EXP_CAPS);
    do_read(3'd7, d); chk("reserved", d, 32'd0);
    do_read(3'd5, d); chk("hi_after_rst", d, 32'd0);

    // T2: byte-lane scratch write
    do_write(3'd3, 32'hDEADBEEF, 4'b0101);
    do_read(3'd3, d); chk("scratch_be0101", d, 32'h00AD00EF);

    // T3: writes to RO offsets are ignored
    do_write(3'd0, 32'h12345678, 4'hF);
    do_read(3'd0, d); chk("id_ro", d, 32'hACD51302);
    do_read(3'd3, d); chk("scratch_kept", d, 32'h00AD00EF);
    do_write(3'd3, 32'hFFFFFFFF, 4'b0000);
    do_write(3'd3, 32'h11223344, 4'b1010);
    do_read(3'd3, d); chk("scratch_be1010", d, 32'h11AD33EF);

    // T6: simultaneous read/write to scratch returns pre-write value
    do_reset();
    address = 3'd3; writedata = 32'hA5A5A5A5; byteenable = 4'hF;
    read = 1'b1; write = 1'b1;
    idle(1);
    read = 1'b0; write = 1'b0;
    chk("rw_rdv", {31'd0, readdatavalid}, 32'd1);
    chk("rw_old", readdata, 32'd0);
    do_read(3'd3, d); chk("rw_new", d, 32'hA5A5A5A5);

    // Reset asserted with a read pending drops the response
    do_read(3'd0, d);
    address = 3'd1; read = 1'b1; reset = 1'b1;
    idle(1);
    read = 1'b0;
    chk("rst_mid_rdv", {31'd0, readdatavalid}, 32'd0);
    chk("rst_mid_rdata", readdata, 32'd0);
    reset = 1'b0;

    // T4: uptime after 40 edges with TICK_DIV=4 is 10
    do_reset();
    idle(39);
    do_read(3'd4, d);
`ifdef SOC_SYSID_UPTIME_EN
    chk("uptime_lo40", d, 32'd10);
    do_read(3'd5, d); chk("uptime_hi40", d, 32'd0);

    // T5: carry into the high word on the LO read edge
    force dut.u_uptime.pre = 16'd3;
    force dut.u_uptime.cnt = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_uptime.pre;
    release dut.u_uptime.cnt;
    do_read(3'd4, d); chk("carry_lo", d, 32'd0);
    do_read(3'd5, d); chk("carry_hi", d, 32'd1);
    do_read(3'd5, d); chk("hi_repeat", d, 32'd1);

    // 64-bit rollover to zero
    force dut.u_uptime.pre = 16'd3;
    force dut.u_uptime.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_uptime.pre;
    release dut.u_uptime.cnt;
    do_read(3'd4, d); chk("wrap_lo", d, 32'd0);
    do_read(3'd5, d); chk("wrap_hi", d, 32'd0);
`else
    chk("uptime_lo_off", d, 32'd0);
    do_read(3'd5, d); chk("uptime_hi_off", d, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
